// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: arbiter state type and default bus widths shared by the wb_arbiter files
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } arb_state_t;

    localparam int DEF_DATA_W  = 128;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: stall counter for the granted bus cycle, pulses o_expire for one cycle at TIMEOUT
//   clk, rst   : clock, asynchronous active-high reset
//   i_stb      : strobe of the granted master, before any masking
//   i_term     : any slave termination (ack, err or rty)
//   i_gnt_chg  : grant is moving at the coming edge
//   o_expire   : stall limit reached this cycle
module wb_arb_watchdog import wb_arb_pkg::*; #(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stb,
    input  logic i_term,
    input  logic i_gnt_chg,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Fires on the TIMEOUT-th stalled cycle itself, so the stalled strobe is withdrawn in that cycle.
    assign o_expire = i_stb && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_term || i_gnt_chg || o_expire)
            r_cnt <= '0;
        else if (i_stb)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master, one-slave Wishbone B4 classic arbiter, cyc-locked, round-robin on contention
//   clk, rst          : clock, asynchronous active-high reset
//   m0_*_i / m0_*_o   : master 0 (cache) Wishbone port
//   m1_*_i / m1_*_o   : master 1 (boot loader / DMA) Wishbone port
//   s_*_o / s_*_i     : slave (RAM) Wishbone port
//   WB_ARB_WATCHDOG_EN: when defined, a stalled strobe is terminated with err after TIMEOUT cycles
module wb_arbiter import wb_arb_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_rty_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_rty_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    output logic [SEL_W-1:0]  s_sel_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i
);

    arb_state_t r_state, w_next;
    logic       r_last;
    logic       w_g0, w_g1, w_stb, w_expire;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (m0_cyc_i && m1_cyc_i) ? (r_last ? GNT0 : GNT1) :
                              m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
            GNT0:    w_next = m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
            GNT1:    w_next = m1_cyc_i ? GNT1 : m0_cyc_i ? GNT0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_last resets to 1 so master 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == GNT0)
                r_last <= 1'b0;
            else if (w_next == GNT1)
                r_last <= 1'b1;
        end
    end

    assign w_g0  = (r_state == GNT0);
    assign w_g1  = (r_state == GNT1);
    assign w_stb = (w_g0 && m0_stb_i) || (w_g1 && m1_stb_i);

    assign s_cyc_o  = (w_g0 && m0_cyc_i) || (w_g1 && m1_cyc_i);
    assign s_stb_o  = w_stb && !w_expire;
    assign s_we_o   = w_g1 ? m1_we_i  : m0_we_i;
    assign s_adr_o  = w_g1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o  = w_g1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o  = w_g1 ? m1_sel_i : m0_sel_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = w_g0 && s_ack_i;
    assign m0_err_o = w_g0 && (s_err_i || w_expire);
    assign m0_rty_o = w_g0 && s_rty_i;
    assign m1_ack_o = w_g1 && s_ack_i;
    assign m1_err_o = w_g1 && (s_err_i || w_expire);
    assign m1_rty_o = w_g1 && s_rty_i;

`ifdef WB_ARB_WATCHDOG_EN
    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_stb     (w_stb),
        .i_term    (s_ack_i || s_err_i || s_rty_i),
        .i_gnt_chg (w_next != r_state),
        .o_expire  (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_expire         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic checked against a grant-ownership model
module tb_wb_arbiter;
    localparam int DW = 128;
    localparam int AW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          mc[2], ms[2], mw[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] md[2];
    logic [SW-1:0] msel[2];

    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic [SW-1:0] s_sel_o;
    logic          s_ack_i, s_err_i, s_rty_i;

    logic          ram_mode = 1'b0;
    logic          ram_ack = 1'b0;
    logic [DW-1:0] ram_dat = '0;
    logic [DW-1:0] mem [256];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_adr = '0;
    logic [DW-1:0] pl_dat = '0;
    logic          r_ack = 1'b0, r_err = 1'b0, r_rty = 1'b0;
    logic [DW-1:0] r_dat = '0;

    int n_cmp = 0;
    int n_bad = 0;

    assign s_ack_i = ram_mode ? ram_ack : r_ack;
    assign s_err_i = ram_mode ? 1'b0    : r_err;
    assign s_rty_i = ram_mode ? 1'b0    : r_rty;
    assign s_dat_i = ram_mode ? ram_dat : r_dat;

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_adr_i(ma[0]),
        .m0_dat_i(md[0]), .m0_sel_i(msel[0]), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_adr_i(ma[1]),
        .m1_dat_i(md[1]), .m1_sel_i(msel[1]), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    // Behavioural RAM slave: one-cycle registered ack, byte-masked writes.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_adr] <= pl_dat;
            ram_ack <= 1'b0;
        end else if (s_cyc_o && s_stb_o && !ram_ack) begin
            ram_ack <= 1'b1;
            ram_dat <= mem[s_adr_o[7:0]];
            if (s_we_o)
                for (int b = 0; b < SW; b++)
                    if (s_sel_o[b]) mem[s_adr_o[7:0]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
        end else begin
            ram_ack <= 1'b0;
        end
    end

    // Reference model: who owns the bus (-1 none), who was granted last, stalled-strobe count.
    int own = -1;
    bit lastm = 1'b1;
    int wd = 0;

    function automatic bit own_stb();
        return (own == 0) ? ms[0] : (own == 1) ? ms[1] : 1'b0;
    endfunction

    function automatic bit wd_fire();
`ifdef WB_ARB_WATCHDOG_EN
        return own_stb() && (wd == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own = -1;
            lastm = 1'b1;
            wd = 0;
        end else begin
            int nxt;
            bit ex, term;
            ex = wd_fire();
            term = s_ack_i || s_err_i || s_rty_i;
            if (own < 0)
                nxt = (mc[0] && mc[1]) ? (lastm ? 0 : 1) : mc[0] ? 0 : mc[1] ? 1 : -1;
            else
                nxt = mc[own] ? own : mc[1-own] ? 1 - own : -1;
            if (nxt != own || term || ex) wd = 0;
            else if (own_stb()) wd++;
            if (nxt >= 0) lastm = nxt[0];
            own = nxt;
        end
    end

    task automatic idle_masters();
        for (int n = 0; n < 2; n++) begin
            mc[n] = 1'b0; ms[n] = 1'b0; mw[n] = 1'b0;
            ma[n] = '0; md[n] = '0; msel[n] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_masters();
        r_ack = 1'b0; r_err = 1'b0; r_rty = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_adr = a; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        ram_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin mc[n] = 1'b1; ms[n] = 1'b1; end
        r_ack = 1'b1; r_err = 1'b1; r_rty = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            got = {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o};
            n_cmp++;
            if (got !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got %b want 00000000", k, got);
            end
            @(posedge clk);
        end
        do_reset();
    endtask

    task automatic test_single_master();
        bit got_ack = 0, m1_seen = 0, ack_mis = 0;
        ram_mode = 1'b1;
        do_reset();
        preload(8'h10, {4{32'hDEADBEEF}});
        @(negedge clk);
        mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b0; ma[0] = 16'h0010;
        #1;
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_early_cyc: got %b want 0", s_cyc_o); end
        @(negedge clk);
        n_cmp++;
        if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL single_grant_cyc: got %b want 1", s_cyc_o); end
        for (int i = 0; i < 8 && !got_ack; i++) begin
            if (m1_ack_o) m1_seen = 1;
            if (m0_ack_o !== s_ack_i) ack_mis = 1;
            if (m0_ack_o) got_ack = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!got_ack) begin n_bad++; $display("FAIL single_ack_timeout: got no ack want ack"); end
        n_cmp++;
        if (m0_dat_o !== {4{32'hDEADBEEF}}) begin n_bad++; $display("FAIL single_read_data: got %h want %h", m0_dat_o, {4{32'hDEADBEEF}}); end
        n_cmp++;
        if (ack_mis) begin n_bad++; $display("FAIL single_ack_passthru: got m0_ack!=s_ack want equal"); end
        mc[0] = 1'b0; ms[0] = 1'b0;
        @(negedge clk);
        if (m1_ack_o) m1_seen = 1;
        n_cmp++;
        if (m1_seen) begin n_bad++; $display("FAIL single_m1_ack: got 1 want 0"); end
    endtask

    task automatic test_simultaneous();
        bit got = 0;
        ram_mode = 1'b1;
        do_reset();
        preload(8'h30, {4{32'h0000_3030}});
        preload(8'h40, {4{32'h0000_4040}});
        @(negedge clk);
        mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 16'h0030;
        mc[1] = 1'b1; ms[1] = 1'b1; ma[1] = 16'h0040;
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, 16'h0030}) begin
            n_bad++; $display("FAIL simul_first_grant: got cyc=%b adr=%h want cyc=1 adr=0030", s_cyc_o, s_adr_o);
        end
        for (int i = 0; i < 8 && !got; i++) if (m0_ack_o) got = 1; else @(negedge clk);
        mc[0] = 1'b0; ms[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, 16'h0040}) begin
            n_bad++; $display("FAIL simul_handoff: got cyc=%b adr=%h want cyc=1 adr=0040", s_cyc_o, s_adr_o);
        end
        got = 0;
        for (int i = 0; i < 8 && !got; i++) if (m1_ack_o) got = 1; else @(negedge clk);
        n_cmp++;
        if (!got || m1_dat_o !== {4{32'h0000_4040}}) begin
            n_bad++; $display("FAIL simul_m1_read: got ack=%b dat=%h want ack=1 dat=%h", got, m1_dat_o, {4{32'h0000_4040}});
        end
        idle_masters();
    endtask

    task automatic test_round_robin();
        int k = 0;
        bit order[8];
        bit a[2];
        ram_mode = 1'b1;
        do_reset();
        ma[0] = 16'h0050; ma[1] = 16'h0060;
        for (int i = 0; i < 200 && k < 8; i++) begin
            @(negedge clk);
            a[0] = m0_ack_o; a[1] = m1_ack_o;
            if (a[0] || a[1]) begin order[k] = a[1]; k++; end
            for (int n = 0; n < 2; n++)
                if (a[n]) begin mc[n] = 1'b0; ms[n] = 1'b0; end
                else if (!mc[n]) begin mc[n] = 1'b1; ms[n] = 1'b1; end
        end
        n_cmp++;
        if (k != 8) begin n_bad++; $display("FAIL rr_timeout: got %0d grants want 8", k); end
        for (int j = 0; j < k; j++) begin
            n_cmp++;
            if (order[j] !== 1'(j % 2)) begin
                n_bad++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", j, order[j], j % 2);
            end
        end
        idle_masters();
    endtask

    task automatic test_write_isolation();
        bit got = 0, early = 0;
        logic [DW-1:0] want;
        want = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0000_1234};
        ram_mode = 1'b1;
        do_reset();
        preload(8'h20, {DW{1'b1}});
        @(negedge clk);
        mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b1; ma[1] = 16'h0020;
        md[1] = 128'h1234; msel[1] = 16'h000F;
        @(negedge clk);
        mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b0; ma[0] = 16'h0020;
        for (int i = 0; i < 8 && !got; i++) begin
            if (m0_ack_o) early = 1;
            if (m1_ack_o) got = 1; else @(negedge clk);
        end
        mc[1] = 1'b0; ms[1] = 1'b0; mw[1] = 1'b0;
        n_cmp++;
        if (early) begin n_bad++; $display("FAIL wiso_early_ack: got m0 ack during m1 grant want none"); end
        got = 0;
        @(negedge clk);
        for (int i = 0; i < 8 && !got; i++) if (m0_ack_o) got = 1; else @(negedge clk);
        n_cmp++;
        if (!got || m0_dat_o !== want) begin
            n_bad++; $display("FAIL wiso_readback: got ack=%b dat=%h want ack=1 dat=%h", got, m0_dat_o, want);
        end
        idle_masters();
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        ram_mode = 1'b1;
        do_reset();
        @(negedge clk);
        mc[1] = 1'b1; ms[1] = 1'b1; ma[1] = 16'h0070;
        @(negedge clk);
        mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 16'h0080;
        n_cmp++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, 16'h0070}) begin
            n_bad++; $display("FAIL rmid_m1_grant: got cyc=%b adr=%h want cyc=1 adr=0070", s_cyc_o, s_adr_o);
        end
        #2 rst = 1'b1;
        #1;
        got = {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o};
        n_cmp++;
        if (got !== 8'h00) begin n_bad++; $display("FAIL rmid_async_clear: got %b want 00000000", got); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, 16'h0080}) begin
            n_bad++; $display("FAIL rmid_m0_after_reset: got cyc=%b adr=%h want cyc=1 adr=0080", s_cyc_o, s_adr_o);
        end
        idle_masters();
    endtask

`ifdef WB_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        logic [1:0] got, want;
        ram_mode = 1'b0;
        do_reset();
        @(negedge clk);
        mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 16'h0090;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            got = {m0_err_o, s_stb_o};
            want = (c == TO) ? 2'b10 : 2'b01;
            n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL wd_cycle[%0d]: got err,stb=%b want %b", c, got, want);
            end
        end
        idle_masters();
    endtask
`endif

    task automatic test_random();
        logic [7:0] got_c, exp_c;
        logic [AW+DW+SW:0] got_d, exp_d;
        bit ex, g0, g1;
        ram_mode = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(3) == 0) mc[n] = ~mc[n];
                ms[n] = mc[n] & 1'($urandom_range(1));
                mw[n] = 1'($urandom);
                ma[n] = AW'($urandom);
                md[n] = {$urandom, $urandom, $urandom, $urandom};
                msel[n] = SW'($urandom);
            end
            r_ack = ($urandom_range(2) == 0);
            r_err = ($urandom_range(7) == 0);
            r_rty = ($urandom_range(7) == 0);
            r_dat = {$urandom, $urandom, $urandom, $urandom};
            #1;
            ex = wd_fire();
            g0 = (own == 0);
            g1 = (own == 1);
            exp_c = {(g0 && mc[0]) || (g1 && mc[1]), ((g0 && ms[0]) || (g1 && ms[1])) && !ex,
                     g0 && r_ack, g0 && (r_err || ex), g0 && r_rty,
                     g1 && r_ack, g1 && (r_err || ex), g1 && r_rty};
            got_c = {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o};
            n_cmp++;
            if (got_c !== exp_c) begin
                n_bad++; $display("FAIL rand_ctrl[%0d]: got %b want %b (owner %0d)", i, got_c, exp_c, own);
            end
            n_cmp++;
            if (m0_dat_o !== r_dat || m1_dat_o !== r_dat) begin
                n_bad++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h", i, m0_dat_o, m1_dat_o, r_dat);
            end
            if (own >= 0) begin
                exp_d = {mw[own], ma[own], md[own], msel[own]};
                got_d = {s_we_o, s_adr_o, s_dat_o, s_sel_o};
                n_cmp++;
                if (got_d !== exp_d) begin
                    n_bad++; $display("FAIL rand_mux[%0d]: got %h want %h (owner %0d)", i, got_d, exp_d, own);
                end
            end
        end
        idle_masters();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_masters();
        test_reset();
        test_single_master();
        test_simultaneous();
        test_round_robin();
        test_write_isolation();
        test_reset_mid();
`ifdef WB_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
